// File: rtl/gap_mem_arb.sv
// gap_mem_arb: single-port arbiter for one GAP-TV frame-buffer SRAM row port.
// Reads go straight to memory; writes are posted into a small FIFO that drains
// on idle cycles, or is forced to drain when it is full, when its head has waited
// too long, or when a read targets a row that still has a write queued.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rd_req/rd_addr      read request and row address (held until rd_gnt)
//   rd_gnt              read issued to memory this cycle
//   rd_valid/rd_data    read row data, one cycle after rd_gnt
//   wr_req/wr_addr/
//   wr_data             write request, row address and row data
//   wr_rdy              FIFO can accept; write taken when wr_req & wr_rdy
//   mem_en/mem_we/
//   mem_addr/mem_wdata  SRAM access strobe, direction, address, write data
//   mem_rdata           SRAM read data, one cycle after a read strobe
//   wq_cnt              posted-write FIFO occupancy
module gap_mem_arb #(
    parameter int ADDR_W    = 8,
    parameter int PORT_SIZE = 32,
    parameter int DATA_W    = 16,
    parameter int WQ_DEPTH  = 4,
    parameter int MAX_STALL = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rd_req,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic                          rd_gnt,
    output logic                          rd_valid,
    output logic [PORT_SIZE*DATA_W-1:0]   rd_data,
    input  logic                          wr_req,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [PORT_SIZE*DATA_W-1:0]   wr_data,
    output logic                          wr_rdy,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [PORT_SIZE*DATA_W-1:0]   mem_wdata,
    input  logic [PORT_SIZE*DATA_W-1:0]   mem_rdata,
    output logic [$clog2(WQ_DEPTH):0]     wq_cnt
);

    localparam int ROW_W   = PORT_SIZE * DATA_W;
    localparam int PTR_W   = $clog2(WQ_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int STALL_W = $clog2(MAX_STALL + 1);

    localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(WQ_DEPTH);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(MAX_STALL);

    // Posted-write FIFO storage
    logic [ADDR_W-1:0]   q_addr [WQ_DEPTH];
    logic [ROW_W-1:0]    q_data [WQ_DEPTH];
    logic [WQ_DEPTH-1:0] q_vld;
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [CNT_W-1:0]    cnt;
    logic [STALL_W-1:0]  stall_cnt;

    // Per-cycle control
    logic non_empty;
    logic full;
    logic hazard;
    logic force_drain;
    logic drain;
    logic rd_issue;
    logic push;
    logic pop;

    assign non_empty = (cnt != '0);
    assign full      = (cnt == CNT_FULL);

    // Hazard looks only at entries valid at cycle start, so a write accepted
    // in the same cycle as a read is ordered after that read.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < WQ_DEPTH; i++) begin
            if (q_vld[i] && (q_addr[i] == rd_addr)) begin
                hazard = 1'b1;
            end
        end
    end

    assign force_drain = non_empty
                       & (full | (stall_cnt >= STALL_MAX) | (rd_req & hazard));

    // Drain when forced, or when the port would otherwise sit idle.
    assign drain    = ~rst & non_empty & (force_drain | ~rd_req);
    assign rd_issue = ~rst & ~force_drain & rd_req;

    // No bypass: a full FIFO refuses writes even in a cycle that pops.
    assign wr_rdy = ~rst & (cnt < CNT_FULL);
    assign push   = wr_req & wr_rdy;
    assign pop    = drain;

    assign rd_gnt = rd_issue;

    // Memory port, one operation per cycle
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (drain) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = q_addr[head];
            mem_wdata = q_data[head];
        end else if (rd_issue) begin
            mem_en    = 1'b1;
            mem_addr  = rd_addr;
        end
    end

    // Entry payload needs no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[tail] <= wr_addr;
            q_data[tail] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_vld <= '0;
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
        end else begin
            if (pop) begin
                q_vld[head] <= 1'b0;
                head        <= head + PTR_W'(1);
            end
            if (push) begin
                q_vld[tail] <= 1'b1;
                tail        <= tail + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Counts cycles the head has waited behind reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (drain || !non_empty) begin
            stall_cnt <= '0;
        end else if (stall_cnt < STALL_MAX) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_issue;
        end
    end

    assign rd_data = rd_valid ? mem_rdata : '0;
    assign wq_cnt  = rst ? '0 : cnt;

endmodule

// File: tb/tb_gap_mem_arb.sv
// tb_gap_mem_arb: directed bench for gap_mem_arb with a behavioural SRAM.
// Covers reset, plain reads, write posting, forced drains, hazards and reset flush.
module tb_gap_mem_arb;

    localparam int ADDR_W    = 8;
    localparam int PORT_SIZE = 32;
    localparam int DATA_W    = 16;
    localparam int WQ_DEPTH  = 4;
    localparam int MAX_STALL = 15;
    localparam int ROW_W     = PORT_SIZE * DATA_W;

    logic                          clk;
    logic                          rst;
    logic                          rd_req;
    logic [ADDR_W-1:0]             rd_addr;
    logic                          rd_gnt;
    logic                          rd_valid;
    logic [ROW_W-1:0]              rd_data;
    logic                          wr_req;
    logic [ADDR_W-1:0]             wr_addr;
    logic [ROW_W-1:0]              wr_data;
    logic                          wr_rdy;
    logic                          mem_en;
    logic                          mem_we;
    logic [ADDR_W-1:0]             mem_addr;
    logic [ROW_W-1:0]              mem_wdata;
    logic [ROW_W-1:0]              mem_rdata;
    logic [$clog2(WQ_DEPTH):0]     wq_cnt;

    int n_chk = 0;
    int n_err = 0;

    gap_mem_arb #(
        .ADDR_W    (ADDR_W),
        .PORT_SIZE (PORT_SIZE),
        .DATA_W    (DATA_W),
        .WQ_DEPTH  (WQ_DEPTH),
        .MAX_STALL (MAX_STALL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_rdy    (wr_rdy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .wq_cnt    (wq_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: reset loads row i with pixels 16'h00ii.
    logic [ROW_W-1:0]  mem [256];
    logic [ADDR_W-1:0] wlog [$];
    int                we_count = 0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] <= {PORT_SIZE{{8'h00, 8'(i)}}};
            end
        end
        if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wlog.push_back(mem_addr);
            we_count <= we_count + 1;
        end
        if (mem_en && !mem_we) begin
            mem_rdata <= mem[mem_addr];
        end
    end

    function automatic logic [ROW_W-1:0] row(input logic [15:0] p);
        return {PORT_SIZE{p}};
    endfunction

    task automatic check(input string tag,
                         input logic [ROW_W-1:0] got,
                         input logic [ROW_W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a read until granted (bounded); waits = cycles refused.
    task automatic rd_wait(input logic [ADDR_W-1:0] a, output int waits);
        waits   = 0;
        rd_req  = 1'b1;
        rd_addr = a;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rd_gnt) break;
            waits++;
            tick();
        end
        tick();
        rd_req = 1'b0;
    endtask

    int  w;
    int  waits;
    bit  seen;
    int  we_before;
    logic [ADDR_W-1:0] la;

    initial begin
        rst     = 1'b1;
        rd_req  = 1'b0;
        rd_addr = '0;
        wr_req  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        tick();
        // Requests during reset must be ignored.
        rd_req  = 1'b1;
        rd_addr = 8'h10;
        wr_req  = 1'b1;
        wr_addr = 8'h11;
        @(negedge clk);
        check("rst_gnt", ROW_W'(rd_gnt), ROW_W'(0));
        check("rst_rdy", ROW_W'(wr_rdy), ROW_W'(0));
        check("rst_en",  ROW_W'(mem_en), ROW_W'(0));
        check("rst_cnt", ROW_W'(wq_cnt), ROW_W'(0));
        tick();

        // 1: read on idle FIFO
        rst    = 1'b0;
        wr_req = 1'b0;
        @(negedge clk);
        check("t1_gnt",  ROW_W'(rd_gnt),   ROW_W'(1));
        check("t1_we",   ROW_W'(mem_we),   ROW_W'(0));
        check("t1_addr", ROW_W'(mem_addr), ROW_W'(8'h10));
        tick();
        rd_req = 1'b0;
        @(negedge clk);
        check("t1_valid", ROW_W'(rd_valid), ROW_W'(1));
        check("t1_data",  rd_data, row(16'h0010));
        tick();
        check("t1_vdrop", ROW_W'(rd_valid), ROW_W'(0));

        // 2: fill FIFO behind continuous reads, forced drain on full
        wlog.delete();
        rd_req  = 1'b1;
        rd_addr = 8'h80;
        wr_req  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            wr_addr = 8'(k);
            wr_data = row(16'hA000 + 16'(k));
            @(negedge clk);
            check($sformatf("t2_gnt%0d", k), ROW_W'(rd_gnt), ROW_W'(1));
            check($sformatf("t2_rdy%0d", k), ROW_W'(wr_rdy), ROW_W'(1));
            tick();
        end
        wr_addr = 8'h05;
        wr_data = row(16'hA005);
        @(negedge clk);
        check("t2_full_rdy", ROW_W'(wr_rdy),   ROW_W'(0));
        check("t2_full_cnt", ROW_W'(wq_cnt),   ROW_W'(4));
        check("t2_force_we", ROW_W'(mem_we),   ROW_W'(1));
        check("t2_force_ad", ROW_W'(mem_addr), ROW_W'(8'h01));
        check("t2_force_wd", mem_wdata, row(16'hA001));
        check("t2_force_gn", ROW_W'(rd_gnt),   ROW_W'(0));
        tick();
        wr_req = 1'b0;
        @(negedge clk);
        check("t2_cnt3", ROW_W'(wq_cnt), ROW_W'(3));
        check("t2_regnt", ROW_W'(rd_gnt), ROW_W'(1));
        tick();
        rd_req = 1'b0;
        for (int k = 0; k < 20 && wq_cnt != 0; k++) tick();
        check("t2_drained", ROW_W'(wq_cnt), ROW_W'(0));
        check("t2_nwr", ROW_W'(wlog.size()), ROW_W'(4));
        for (int k = 0; k < 4; k++) begin
            la = (k < wlog.size()) ? wlog[k] : 8'hFF;
            check($sformatf("t2_order%0d", k), ROW_W'(la), ROW_W'(k + 1));
            check($sformatf("t2_mem%0d", k + 1), mem[k + 1],
                  row(16'hA001 + 16'(k)));
        end

        // 3: read-after-write hazard
        wr_req  = 1'b1;
        wr_addr = 8'h20;
        wr_data = row(16'hAAAA);
        @(negedge clk);
        check("t3_idle", ROW_W'(mem_en), ROW_W'(0));
        check("t3_rdy",  ROW_W'(wr_rdy), ROW_W'(1));
        tick();
        wr_req = 1'b0;
        rd_wait(8'h20, w);
        check("t3_wait", ROW_W'(w), ROW_W'(1));
        @(negedge clk);
        check("t3_valid", ROW_W'(rd_valid), ROW_W'(1));
        check("t3_data",  rd_data, row(16'hAAAA));
        tick();

        // 4: stall limit under continuous reads
        rd_req  = 1'b1;
        rd_addr = 8'h90;
        wr_req  = 1'b1;
        wr_addr = 8'h40;
        wr_data = row(16'h5555);
        @(negedge clk);
        check("t4_gnt0", ROW_W'(rd_gnt), ROW_W'(1));
        tick();
        wr_req = 1'b0;
        waits  = 0;
        seen   = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (mem_en && mem_we) begin
                seen = 1'b1;
            end else begin
                if (rd_gnt) waits++;
                tick();
            end
        end
        check("t4_seen",  ROW_W'(seen),     ROW_W'(1));
        check("t4_waits", ROW_W'(waits),    ROW_W'(MAX_STALL));
        check("t4_addr",  ROW_W'(mem_addr), ROW_W'(8'h40));
        check("t4_gnt",   ROW_W'(rd_gnt),   ROW_W'(0));
        tick();
        rd_req = 1'b0;
        tick();

        // 5: two writes to one row, read sees the newer one
        rd_req  = 1'b1;
        rd_addr = 8'hA0;
        wr_req  = 1'b1;
        wr_addr = 8'h30;
        wr_data = row(16'h1111);
        tick();
        wr_data = row(16'h2222);
        @(negedge clk);
        check("t5_cnt1", ROW_W'(wq_cnt), ROW_W'(1));
        tick();
        wr_req = 1'b0;
        rd_wait(8'h30, w);
        check("t5_wait", ROW_W'(w), ROW_W'(2));
        @(negedge clk);
        check("t5_data",  rd_data, row(16'h2222));
        check("t5_empty", ROW_W'(wq_cnt), ROW_W'(0));
        check("t5_mem",   mem[8'h30], row(16'h2222));
        tick();

        // 6: reset flushes queued writes
        we_before = we_count;
        rd_req  = 1'b1;
        rd_addr = 8'hB0;
        wr_req  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wr_addr = 8'h50 + 8'(k);
            wr_data = row(16'hBEEF);
            tick();
        end
        wr_req = 1'b0;
        @(negedge clk);
        check("t6_cnt3", ROW_W'(wq_cnt), ROW_W'(3));
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("t6_rcnt", ROW_W'(wq_cnt), ROW_W'(0));
        check("t6_ren",  ROW_W'(mem_en), ROW_W'(0));
        check("t6_rgnt", ROW_W'(rd_gnt), ROW_W'(0));
        tick();
        rst    = 1'b0;
        rd_req = 1'b0;
        @(negedge clk);
        check("t6_valid", ROW_W'(rd_valid), ROW_W'(0));
        check("t6_cnt",   ROW_W'(wq_cnt),   ROW_W'(0));
        check("t6_en",    ROW_W'(mem_en),   ROW_W'(0));
        repeat (3) tick();
        check("t6_nowe", ROW_W'(we_count), ROW_W'(we_before));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
